// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types, constants and BCD helpers for the score keeper and display scanner.
package seg_scan_ctrl_pkg;

  localparam int         SCAN_DIV_DEFAULT = 100000;
  localparam logic [3:0] AN_OFF           = 4'b1111;
  localparam int         NUM_DIGITS       = 4;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [1:0] digit_idx_t;

  typedef struct packed {
    bcd_digit_t num;
    logic       blank;
  } slot_t;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // A digit is blank when it and every more-significant digit are zero; units never blank.
  function automatic slot_t slot_for(input logic [15:0] bcd, input digit_idx_t idx);
    slot_t       s;
    logic [15:0] upper;
    upper   = bcd >> {idx, 2'b00};
    s.blank = (idx != 2'd0) && (upper == 16'h0000);
    s.num   = s.blank ? 4'd0 : upper[3:0];
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Score event inputs and display/score outputs of the scanner, bundled with modports.
interface seg_scan_ctrl_if;
  import seg_scan_ctrl_pkg::*;

  logic       score_inc;
  logic       score_clr;
  bcd_digit_t num;
  logic [3:0] an;
  logic [15:0] score_bcd;
  logic       score_max;

  modport master (output score_inc, score_clr, input num, an, score_bcd, score_max);
  modport slave  (input score_inc, score_clr, output num, an, score_bcd, score_max);
endinterface

// File: rtl/seg_scan_ctrl_bcd_counter4.sv
// Four-digit BCD score counter: saturates at 9999, clear has priority over increment.
module bcd_counter4
  import seg_scan_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] bcd,
  output logic        max
);

  localparam logic [15:0] BCD_MAX = 16'h9999;

  logic [15:0] next_bcd_s;

  // Next score value from clear/increment requests.
  always_comb begin
    next_bcd_s = bcd;
    if (clr) begin
      next_bcd_s = 16'h0000;
    end else if (inc && (bcd != BCD_MAX)) begin
      next_bcd_s = bcd_inc(bcd);
    end else begin
      next_bcd_s = bcd;
    end
  end

  // Score and saturation flag registers, updated together.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd <= 16'h0000;
      max <= 1'b0;
    end else begin
      bcd <= next_bcd_s;
      max <= (next_bcd_s == BCD_MAX);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Score keeper and 4-digit multiplexed 7-segment scanner; anode bus trails num by one
// cycle to match the external seg_decoder's output register.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT,
  parameter int DIV_W    = 17
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl_if.slave bus
);

  logic [DIV_W-1:0] div_r;
  digit_idx_t       idx_r;
  logic             blank_r;
  bcd_digit_t       num_r;
  logic [3:0]       an_r;

  logic [15:0]      bcd_s;
  logic             max_s;
  logic             tick_s;
  digit_idx_t       idx_next_s;
  slot_t            slot_next_s;

  bcd_counter4 u_counter (
    .clk (clk),
    .rst (rst),
    .inc (bus.score_inc),
    .clr (bus.score_clr),
    .bcd (bcd_s),
    .max (max_s)
  );

  assign tick_s      = (div_r == DIV_W'(SCAN_DIV - 1));
  assign idx_next_s  = idx_r + 2'd1;
  assign slot_next_s = slot_for(bcd_s, idx_next_s);

  // Slot divider, digit index and the num/an output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r   <= '0;
      idx_r   <= 2'd0;
      blank_r <= 1'b0;
      num_r   <= 4'd0;
      an_r    <= AN_OFF;
    end else begin
      // an is built from the slot state num was loaded with, so it lands one edge later.
      an_r <= blank_r ? AN_OFF : ~(4'b0001 << idx_r);
      if (tick_s) begin
        div_r   <= '0;
        idx_r   <= idx_next_s;
        blank_r <= slot_next_s.blank;
        num_r   <= slot_next_s.num;
      end else begin
        div_r   <= div_r + DIV_W'(1);
        idx_r   <= idx_r;
        blank_r <= blank_r;
        num_r   <= num_r;
      end
    end
  end

  assign bus.num       = num_r;
  assign bus.an        = an_r;
  assign bus.score_bcd = bcd_s;
  assign bus.score_max = max_s;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: score vectors from a table plus scan/reset sequences.
module tb_seg_scan_ctrl;
  import seg_scan_ctrl_pkg::*;

  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] dec_num;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.SCAN_DIV(SD), .DIV_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for seg_decoder: its code follows num one cycle late.
  always @(posedge clk) dec_num <= bus.num;

  always @(negedge clk) begin
    checks++;
    if (bus.num > 4'd9) begin
      errors++;
      $display("FAIL num_range: got %0d required <= 9", bus.num);
    end
  end

  typedef struct {
    bit          clr;
    int          incs;
    logic [15:0] exp_bcd;
    bit          exp_max;
  } vec_t;

  vec_t vecs [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic pulse_inc(input int n);
    if (n > 0) begin
      bus.score_inc = 1'b1;
      repeat (n) step();
      bus.score_inc = 1'b0;
    end
  endtask

  task automatic scan_check(input string name, input logic [15:0] exp_bcd, input logic [3:0] exp_seen);
    logic [3:0] seen;
    int k;
    seen = 4'b0000;
    repeat (4 * SD + 2) step();
    for (int c = 0; c < 8 * SD; c++) begin
      step();
      if (bus.an != 4'b1111) begin
        k = -1;
        for (int j = 0; j < 4; j++) begin
          if (bus.an == ~(4'b0001 << j)) k = j;
        end
        if (k < 0) begin
          checks++;
          errors++;
          $display("FAIL %s_an_onehot: got %b required one-hot-low or 1111", name, bus.an);
        end else begin
          seen[k] = 1'b1;
          check({name, "_digit"}, 32'(dec_num), 32'(exp_bcd[4*k +: 4]));
        end
      end
    end
    check({name, "_seen"}, 32'(seen), 32'(exp_seen));
  endtask

  initial begin
    int waited;
    vecs[0]  = '{1'b1,   0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0,   1, 16'h0001, 1'b0};
    vecs[2]  = '{1'b0,   8, 16'h0009, 1'b0};
    vecs[3]  = '{1'b0,   1, 16'h0010, 1'b0};
    vecs[4]  = '{1'b0,  89, 16'h0099, 1'b0};
    vecs[5]  = '{1'b0,   1, 16'h0100, 1'b0};
    vecs[6]  = '{1'b0,  23, 16'h0123, 1'b0};
    vecs[7]  = '{1'b1,  42, 16'h0042, 1'b0};
    vecs[8]  = '{1'b0, 957, 16'h0999, 1'b0};
    vecs[9]  = '{1'b0,   1, 16'h1000, 1'b0};
    vecs[10] = '{1'b1, 123, 16'h0123, 1'b0};

    rst           = 1'b1;
    bus.score_inc = 1'b0;
    bus.score_clr = 1'b0;
    repeat (3) step();
    check("rst_num", 32'(bus.num), 32'h0);
    check("rst_an", 32'(bus.an), 32'hF);
    check("rst_bcd", 32'(bus.score_bcd), 32'h0);
    check("rst_max", 32'(bus.score_max), 32'h0);
    rst = 1'b0;
    step();
    check("first_an", 32'(bus.an), 32'hE);

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].clr) begin
        bus.score_clr = 1'b1;
        step();
        bus.score_clr = 1'b0;
      end
      pulse_inc(vecs[v].incs);
      check($sformatf("vec%0d_bcd", v), 32'(bus.score_bcd), 32'(vecs[v].exp_bcd));
      check($sformatf("vec%0d_max", v), 32'(bus.score_max), 32'(vecs[v].exp_max));
    end

    scan_check("scan0123", 16'h0123, 4'b0111);

    // Reset in the middle of the hundreds slot.
    waited = 0;
    while (bus.an != 4'b1011 && waited < 40) begin
      step();
      waited++;
    end
    check("wait_idx2", 32'(bus.an), 32'hB);
    step();
    rst = 1'b1;
    step();
    check("midrst_an", 32'(bus.an), 32'hF);
    check("midrst_num", 32'(bus.num), 32'h0);
    check("midrst_bcd", 32'(bus.score_bcd), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < SD; i++) begin
      step();
      check("restart_an0", 32'(bus.an), 32'hE);
      check("restart_num", 32'(bus.num), 32'h0);
    end
    step();
    check("restart_an1_blank", 32'(bus.an), 32'hF);

    pulse_inc(42);
    check("pre_clr_bcd", 32'(bus.score_bcd), 32'h0042);
    bus.score_clr = 1'b1;
    bus.score_inc = 1'b1;
    step();
    bus.score_clr = 1'b0;
    bus.score_inc = 1'b0;
    check("clr_prio_bcd", 32'(bus.score_bcd), 32'h0);
    scan_check("scan0000", 16'h0000, 4'b0001);

    pulse_inc(9998);
    check("b9998_bcd", 32'(bus.score_bcd), 32'h9998);
    check("b9998_max", 32'(bus.score_max), 32'h0);
    pulse_inc(1);
    check("b9999_bcd", 32'(bus.score_bcd), 32'h9999);
    check("b9999_max", 32'(bus.score_max), 32'h1);
    pulse_inc(5);
    check("sat_bcd", 32'(bus.score_bcd), 32'h9999);
    check("sat_max", 32'(bus.score_max), 32'h1);
    scan_check("scan9999", 16'h9999, 4'b1111);
    bus.score_clr = 1'b1;
    step();
    bus.score_clr = 1'b0;
    check("clr_max", 32'(bus.score_max), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
